// File: rtl/rx_word_aligner_if.sv
// Word aligner handshake bundle: raw word and controls in,
// aligned word, lock status, shift and error count out.
`timescale 1ns/1ps
interface rx_word_aligner_if #(
  parameter int WIDTH = 16
);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] din;
  logic             train_en;
  logic             relock;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             locked;
  logic [SW-1:0]    shift;
  logic [7:0]       err_cnt;

  modport master (
    output din, train_en, relock,
    input  dout, dout_valid, locked, shift, err_cnt
  );

  modport slave (
    input  din, train_en, relock,
    output dout, dout_valid, locked, shift, err_cnt
  );
endinterface

// File: rtl/rx_word_aligner.sv
// Finds the training pattern in the raw deserializer stream, locks a
// bit shift, emits aligned words and counts pattern errors.
//   clk, rstb (sync, active-low); bus: rx_word_aligner_if.slave
`timescale 1ns/1ps
module rx_word_aligner #(
  parameter int          WIDTH         = 16,
  parameter logic [15:0] TRAIN_PATTERN = 16'hF0A5,
  parameter int          LOCK_COUNT    = 4,
  parameter int          UNLOCK_COUNT  = 3,
  parameter int          SW            = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rstb,
  rx_word_aligner_if.slave bus
);

  localparam logic [WIDTH-1:0] PAT = WIDTH'(TRAIN_PATTERN);
  localparam logic [3:0] LC_M1 = 4'(LOCK_COUNT - 1);
  localparam logic [3:0] UC_M1 = 4'(UNLOCK_COUNT - 1);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             locked_q;
  logic [SW-1:0]    shift_q;
  logic [7:0]       err_q;
  logic [3:0]       match_cnt;
  logic [3:0]       miss_cnt;

  logic [2*WIDTH-1:0] cat;
  logic [WIDTH-1:0]   cur_win;
  logic               cur_hit;
  logic               hit_any;
  logic [SW-1:0]      hit_s;

  assign cat     = {bus.din, prev};
  assign cur_win = cat[shift_q +: WIDTH];
  assign cur_hit = (cur_win == PAT);

  // Scan downward so the lowest matching offset wins.
  always_comb begin
    hit_any = 1'b0;
    hit_s   = '0;
    for (int s = WIDTH - 1; s >= 0; s--) begin
      if (cat[s +: WIDTH] == PAT) begin
        hit_any = 1'b1;
        hit_s   = SW'(s);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= SEARCH;
      prev      <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      shift_q   <= '0;
      err_q     <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      prev   <= bus.din;
      dout_q <= cur_win;
      if (bus.relock) begin
        state     <= SEARCH;
        valid_q   <= 1'b0;
        locked_q  <= 1'b0;
        err_q     <= '0;
        match_cnt <= '0;
        miss_cnt  <= '0;
      end else begin
        unique case (state)
          SEARCH: begin
            if (hit_any) begin
              shift_q   <= hit_s;
              match_cnt <= 4'd1;
              if (LOCK_COUNT == 1) begin
                state    <= LOCKED;
                miss_cnt <= '0;
                valid_q  <= 1'b1;
                locked_q <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (cur_hit) begin
              match_cnt <= match_cnt + 4'd1;
              if (match_cnt == LC_M1) begin
                state    <= LOCKED;
                miss_cnt <= '0;
                valid_q  <= 1'b1;
                locked_q <= 1'b1;
              end
            end else begin
              state <= SEARCH;
            end
          end
          LOCKED: begin
            if (bus.train_en) begin
              if (!cur_hit) begin
                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                miss_cnt <= miss_cnt + 4'd1;
                if (miss_cnt == UC_M1) begin
                  state    <= SEARCH;
                  valid_q  <= 1'b0;
                  locked_q <= 1'b0;
                end
              end else begin
                miss_cnt <= '0;
              end
            end
          end
          default: begin
            state    <= SEARCH;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.locked     = locked_q;
  assign bus.shift      = shift_q;
  assign bus.err_cnt    = err_q;

endmodule

// File: doc/rx_word_aligner.md
Name: rx_word_aligner

Overview:
Sits directly downstream of the receive tree deserializer and runs in the deserializer's slowest clock domain. Its input is the raw 2**STAGES-bit parallel word, which carries an arbitrary bit-slip relative to the transmitted word boundary. The block searches the stream for a training pattern, verifies it, and locks a shift value. It then emits boundary-aligned words with a valid flag, monitors lock during training, and reports bit errors.

Parameters:
- WIDTH, 2**`SERDES_STAGES: parallel word width; power of two, at least 2.
- TRAIN_PATTERN, 16'hF0A5 (zero-extended or truncated to WIDTH): training word. Must not equal any nontrivial rotation of itself.
- LOCK_COUNT, 4: consecutive matching words required at one shift before lock is declared; range 1..15.
- UNLOCK_COUNT, 3: consecutive mismatches while locked and training before lock is dropped; range 1..15.
- SW, $clog2(WIDTH): width of the shift field.

Ports:
- clk, input, 1: slow deserializer clock; all logic is on its rising edge.
- rstb, input, 1: reset; one clock; reset is synchronous and active-low.
- din, input, WIDTH: raw deserializer word. din[0] is the earliest bit received.
- train_en, input, 1: far end is sending TRAIN_PATTERN; enables lock monitoring.
- relock, input, 1: single-cycle request to drop lock and re-search.
- dout, output, WIDTH: aligned word; dout[0] is the earliest bit.
- dout_valid, output, 1: dout is aligned data.
- locked, output, 1: high in state LOCKED.
- shift, output, SW: selected bit offset.
- err_cnt, output, 8: saturating count of pattern mismatches while locked.

Behaviour:
- Datapath: register prev <= din every cycle. Define window W(s) = {din, prev}[s +: WIDTH] for s in 0..WIDTH-1. The 2*WIDTH concatenation has din in the upper half.
- Output timing: dout <= W(shift) every cycle, in every state, so dout is registered with one-cycle latency. dout_valid <= (next state == LOCKED). When valid, dout and dout_valid appear on the same cycle as locked.
- Reset (synchronous, rstb low at a clk edge), applies from any state, including mid-verify or locked:
  - state = SEARCH;
  - prev, dout, shift, err_cnt, match_cnt and miss_cnt = 0;
  - dout_valid and locked = 0.
- FSM states are SEARCH, VERIFY and LOCKED.
- SEARCH:
  - Compare W(s) against TRAIN_PATTERN for all s in parallel.
  - On any match, shift <= lowest matching s; match_cnt <= 1.
  - If LOCK_COUNT == 1, go directly to LOCKED; otherwise go to VERIFY.
  - With no match, stay in SEARCH and leave shift unchanged.
- VERIFY:
  - If W(shift) == TRAIN_PATTERN, match_cnt++.
  - When match_cnt reaches LOCK_COUNT (i.e. it was LOCK_COUNT-1 on a matching cycle), go to LOCKED and set miss_cnt = 0.
  - Any mismatch goes to SEARCH; shift is retained until a new match occurs.
- LOCKED:
  - While train_en = 1, the mismatch path applies when W(shift) != TRAIN_PATTERN:
    - err_cnt++, saturating at 255;
    - miss_cnt++;
    - when miss_cnt reaches UNLOCK_COUNT, go to SEARCH.
  - While train_en = 1, a matching word resets miss_cnt to 0.
  - While train_en = 0, no checking is done, miss_cnt holds, and the block stays LOCKED.
- relock:
  - relock = 1 forces SEARCH at the next edge and clears err_cnt, match_cnt and miss_cnt; shift holds.
  - relock has priority over every state transition; rstb has priority over relock.
- Simultaneous events in LOCKED: if a mismatch and relock occur on the same cycle, err_cnt is cleared, not incremented.
- Boundary, first cycle after reset: prev = 0, so W(s) for s > 0 includes zeros. A match on that cycle is legal and is treated like any other match.
- Boundary, shift = 0: W(0) = prev, which is the full previous word.

Test Plan:
1. Repeated TRAIN_PATTERN delivered with a 5-bit slip (din carries the stream delayed by 5 bit positions), train_en = 1 -> shift = 5, locked rises LOCK_COUNT (4) cycles after the first match, and dout_valid rises with it. After lock, feed a random payload with train_en = 0 -> dout equals the sent words, one cycle after the word completes.
2. Zero slip -> shift = 0 and dout == TRAIN_PATTERN while locked. Separately, a slip of WIDTH-1 -> shift = 15.
3. In VERIFY, corrupt one bit of the third pattern word -> return to SEARCH with locked never asserting, then relock cleanly on the following patterns.
4. While LOCKED with train_en = 1, inject 2 bad words, 1 good word, then 3 bad words -> err_cnt = 5; lock is dropped only after the third consecutive bad word; dout_valid = 0 on the cycle after entering SEARCH.
5. Pulse relock while locked with err_cnt = 7 -> SEARCH next cycle, err_cnt = 0, and the block relocks at the same shift after 4 words. Assert relock together with rstb = 0 -> reset values take effect.
6. Drive rstb low for one cycle mid-VERIFY -> every output is 0 on the next cycle; a subsequent pattern stream locks normally.
